conv_mmio_engine: RTL and testbench



---
 rtl/conv_mmio_pkg.sv | 29 ++
 rtl/conv_mac_lane.sv | 72 +++++++
 rtl/conv_mmio_engine.sv | 170 +++++++++++++++++
 tb/tb_conv_mmio_engine.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_mmio_pkg.sv
// Shared types, register bit positions and address-map helpers for conv_mmio_engine.
// CONV_ACC_SATURATE_EN (optional) selects saturating accumulators in conv_mac_lane.
package conv_mmio_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } conv_state_e;

    localparam int unsigned STATUS_DONE_BIT = 0;
    localparam int unsigned STATUS_BUSY_BIT = 1;
    localparam int unsigned STATUS_OVF_BIT  = 2;
    localparam int unsigned CTRL_START_BIT  = 0;
    localparam int unsigned CTRL_ACC_BIT    = 1;

    function automatic int unsigned weight_base(input int unsigned k);
        return 0 * k;
    endfunction

    function automatic int unsigned data_base(input int unsigned k);
        return k * k;
    endfunction

    function automatic int unsigned result_base(input int unsigned k, input int unsigned lanes);
        return k * k * (lanes + 1);
    endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One convolution lane: registered product feeding an accumulator.
// With CONV_ACC_SATURATE_EN the accumulator clamps at all-ones and flags o_clamp.
module conv_mac_lane #(
    parameter int unsigned PRECISION_WIDTH = 4,
    parameter int unsigned ACC_WIDTH       = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_clr_prod,
    input  logic                       i_clr_acc,
    input  logic                       i_prod_en,
    input  logic                       i_acc_en,
    input  logic [PRECISION_WIDTH-1:0] i_weight,
    input  logic [PRECISION_WIDTH-1:0] i_data,
    output logic [ACC_WIDTH-1:0]       o_result,
    output logic                       o_clamp
);

    localparam int unsigned ProdW = 2 * PRECISION_WIDTH;

    logic [ProdW-1:0]     prod_q, prod_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
`ifdef CONV_ACC_SATURATE_EN
    localparam int unsigned SumW = ACC_WIDTH + 1;
    logic [SumW-1:0] sum;
`endif

    always_comb begin
        prod_d = prod_q;
        if (i_clr_prod) begin
            prod_d = '0;
        end else if (i_prod_en) begin
            prod_d = ProdW'(i_weight) * ProdW'(i_data);
        end
    end

    // Accumulates the product registered on the previous cycle.
    always_comb begin
        acc_d   = acc_q;
        o_clamp = 1'b0;
`ifdef CONV_ACC_SATURATE_EN
        sum = SumW'(acc_q) + SumW'(prod_q);
`endif
        if (i_clr_acc) begin
            acc_d = '0;
        end else if (i_acc_en) begin
`ifdef CONV_ACC_SATURATE_EN
            if (sum[ACC_WIDTH]) begin
                acc_d   = '1;
                o_clamp = 1'b1;
            end else begin
                acc_d = sum[ACC_WIDTH-1:0];
            end
`else
            acc_d = acc_q + ACC_WIDTH'(prod_q);
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
        end
    end

    assign o_result = acc_q;

endmodule

// File: rtl/conv_mmio_engine.sv
// Memory-mapped KxK convolution engine: weight/data banks, tap-serial MAC over LANES lanes.
// Optional CONV_ACC_SATURATE_EN makes results saturate and drives the sticky overflow flag.
module conv_mmio_engine
    import conv_mmio_pkg::*;
#(
    parameter int unsigned PRECISION_WIDTH  = 4,
    parameter int unsigned KERNEL_SIZE      = 3,
    parameter int unsigned LANES            = 8,
    parameter int unsigned VALID_ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned ACC_WIDTH        =
        2 * PRECISION_WIDTH + $clog2(KERNEL_SIZE * KERNEL_SIZE) + 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_we,
    input  logic [VALID_ADDR_WIDTH-1:0] i_write_addr,
    input  logic [DATA_WIDTH-1:0]       i_data,
    input  logic                        i_re,
    input  logic [VALID_ADDR_WIDTH-1:0] i_read_addr,
    output logic [DATA_WIDTH-1:0]       o_data
);

    localparam int unsigned T          = KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned TapW       = (T > 1) ? $clog2(T) : 1;
    localparam int unsigned WBase      = weight_base(KERNEL_SIZE);
    localparam int unsigned DBase      = data_base(KERNEL_SIZE);
    localparam int unsigned RBase      = result_base(KERNEL_SIZE, LANES);
    localparam int unsigned StatusAddr = (32'd1 << VALID_ADDR_WIDTH) - 32'd1;
    localparam int unsigned CtrlAddr   = (32'd1 << VALID_ADDR_WIDTH) - 32'd2;

    logic [PRECISION_WIDTH-1:0] weight_q [T];
    logic [PRECISION_WIDTH-1:0] data_q   [LANES][T];
    logic [ACC_WIDTH-1:0]       result   [LANES];
    logic [LANES-1:0]           lane_clamp;

    conv_state_e   state_q, state_d;
    logic [TapW-1:0] tap_q, tap_d;
    logic          done_q, done_d, ovf_q, ovf_d;
    logic          busy, bank_we, start_wr, status_rd;
    logic          clr_prod, clr_acc, prod_en, acc_en, done_set;
    logic [31:0]   waddr, raddr;
    logic          unused_wdata;

    assign waddr        = 32'(i_write_addr);
    assign raddr        = 32'(i_read_addr);
    assign unused_wdata = ^i_data[DATA_WIDTH-1:PRECISION_WIDTH];

    assign busy      = (state_q != StIdle);
    assign bank_we   = i_we && !busy;
    assign start_wr  = bank_we && (waddr == CtrlAddr) && i_data[CTRL_START_BIT];
    assign status_rd = i_re && (raddr == StatusAddr);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            weight_q <= '{default: '0};
            data_q   <= '{default: '0};
        end else if (bank_we) begin
            for (int unsigned t = 0; t < T; t++) begin
                if (waddr == WBase + t) weight_q[t] <= i_data[PRECISION_WIDTH-1:0];
            end
            for (int unsigned l = 0; l < LANES; l++) begin
                for (int unsigned t = 0; t < T; t++) begin
                    if (waddr == DBase + l * T + t) data_q[l][t] <= i_data[PRECISION_WIDTH-1:0];
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        tap_d    = tap_q;
        clr_prod = 1'b0;
        clr_acc  = 1'b0;
        prod_en  = 1'b0;
        acc_en   = 1'b0;
        done_set = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_wr) begin
                    state_d  = StRun;
                    tap_d    = '0;
                    clr_prod = 1'b1;
                    clr_acc  = !i_data[CTRL_ACC_BIT];
                end
            end
            StRun: begin
                prod_en = 1'b1;
                acc_en  = 1'b1;
                if (tap_q == TapW'(T - 1)) begin
                    state_d = StDrain;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            StDrain: begin
                acc_en   = 1'b1;
                done_set = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Setting a flag wins over the read-to-clear in the same cycle.
    always_comb begin
        done_d = done_q;
        ovf_d  = ovf_q;
        if (status_rd) begin
            done_d = 1'b0;
            ovf_d  = 1'b0;
        end
        if (done_set) done_d = 1'b1;
        if (|lane_clamp) ovf_d = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            tap_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        conv_mac_lane #(
            .PRECISION_WIDTH(PRECISION_WIDTH),
            .ACC_WIDTH      (ACC_WIDTH)
        ) u_lane (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_clr_prod(clr_prod),
            .i_clr_acc (clr_acc),
            .i_prod_en (prod_en),
            .i_acc_en  (acc_en),
            .i_weight  (weight_q[tap_q]),
            .i_data    (data_q[l][tap_q]),
            .o_result  (result[l]),
            .o_clamp   (lane_clamp[l])
        );
    end

    always_comb begin
        o_data = '0;
        if (i_re) begin
            for (int unsigned t = 0; t < T; t++) begin
                if (raddr == WBase + t) o_data = DATA_WIDTH'(weight_q[t]);
            end
            for (int unsigned l = 0; l < LANES; l++) begin
                for (int unsigned t = 0; t < T; t++) begin
                    if (raddr == DBase + l * T + t) o_data = DATA_WIDTH'(data_q[l][t]);
                end
                if (raddr == RBase + l) o_data = DATA_WIDTH'(result[l]);
            end
            if (raddr == StatusAddr) begin
                o_data[STATUS_DONE_BIT] = done_q;
                o_data[STATUS_BUSY_BIT] = busy;
                o_data[STATUS_OVF_BIT]  = ovf_q;
            end
            if (raddr == CtrlAddr) o_data[CTRL_START_BIT] = busy;
        end
    end

endmodule

// File: tb/tb_conv_mmio_engine.sv
// Scoreboard bench for conv_mmio_engine: a default instance and an ACC_WIDTH=12 instance share stimulus.
module tb_conv_mmio_engine;

    localparam int unsigned AW   = 14;
    localparam int unsigned DW   = 32;
    localparam int unsigned T    = 9;
    localparam int unsigned L    = 8;
    localparam int unsigned WB   = 0;
    localparam int unsigned DB   = 9;
    localparam int unsigned RB   = 81;
    localparam int unsigned CTRL = 16382;
    localparam int unsigned STAT = 16383;
`ifdef CONV_ACC_SATURATE_EN
    localparam logic [31:0] SatStatus = 32'd5;
    localparam logic [31:0] SatResult = 32'd4095;
`else
    localparam logic [31:0] SatStatus = 32'd1;
    localparam logic [31:0] SatResult = 32'd1979;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst, i_we, i_re;
    logic [AW-1:0] i_write_addr, i_read_addr;
    logic [DW-1:0] i_data, o_data_a, o_data_b;
    logic          probe;

    string       name_q [$];
    logic [31:0] ea_q [$];
    logic [31:0] eb_q [$];
    int          n_cmp, n_bad;
    string       nm;
    logic [31:0] ea, eb;

    always #5 i_clk = ~i_clk;

    conv_mmio_engine u_dut_a (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_we        (i_we),
        .i_write_addr(i_write_addr),
        .i_data      (i_data),
        .i_re        (i_re),
        .i_read_addr (i_read_addr),
        .o_data      (o_data_a)
    );

    conv_mmio_engine #(.ACC_WIDTH(12)) u_dut_b (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_we        (i_we),
        .i_write_addr(i_write_addr),
        .i_data      (i_data),
        .i_re        (i_re),
        .i_read_addr (i_read_addr),
        .o_data      (o_data_b)
    );

    // Monitor: pops one expectation per probed cycle, away from the active edge.
    always @(negedge i_clk) begin
        if (probe) begin
            if (ea_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard: read with no expectation queued");
            end else begin
                nm = name_q.pop_front();
                ea = ea_q.pop_front();
                eb = eb_q.pop_front();
                n_cmp++;
                if (o_data_a !== ea) begin
                    n_bad++;
                    $display("FAIL %s dut_a: got %0d expected %0d", nm, o_data_a, ea);
                end
                n_cmp++;
                if (o_data_b !== eb) begin
                    n_bad++;
                    $display("FAIL %s dut_b: got %0d expected %0d", nm, o_data_b, eb);
                end
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input int unsigned a, input logic [31:0] d);
        i_we = 1'b1;
        i_write_addr = AW'(a);
        i_data = d;
        tick();
        i_we = 1'b0;
    endtask

    task automatic rd_re(input string n, input int unsigned a, input logic [31:0] xa,
                         input logic [31:0] xb, input logic re);
        name_q.push_back(n);
        ea_q.push_back(xa);
        eb_q.push_back(xb);
        i_re = re;
        i_read_addr = AW'(a);
        probe = 1'b1;
        tick();
        i_re = 1'b0;
        probe = 1'b0;
    endtask

    task automatic rd(input string n, input int unsigned a, input logic [31:0] xa,
                      input logic [31:0] xb);
        rd_re(n, a, xa, xb, 1'b1);
    endtask

    // Write and read the same address in one cycle.
    task automatic wrd(input string n, input int unsigned a, input logic [31:0] d,
                       input logic [31:0] x);
        i_we = 1'b1;
        i_write_addr = AW'(a);
        i_data = d;
        rd(n, a, x, x);
        i_we = 1'b0;
    endtask

    task automatic load(input logic [31:0] w, input logic [31:0] dfix, input bit by_lane);
        for (int t = 0; t < int'(T); t++) wr(WB + t, w);
        for (int l = 0; l < int'(L); l++) begin
            for (int t = 0; t < int'(T); t++) wr(DB + l * T + t, by_lane ? 32'(l) : dfix);
        end
    endtask

    task automatic run(input logic [31:0] c, input logic [31:0] sa, input logic [31:0] sb);
        wr(CTRL, c);
        idle(T + 1);
        rd("run_status", STAT, sa, sb);
    endtask

    task automatic check_results(input string n, input int unsigned mul);
        for (int l = 0; l < int'(L); l++) rd(n, RB + l, 32'(mul * l), 32'(mul * l));
    endtask

    initial begin
        i_rst = 1'b1; i_we = 1'b0; i_re = 1'b0; probe = 1'b0;
        i_write_addr = '0; i_read_addr = '0; i_data = '0;
        n_cmp = 0; n_bad = 0;
        idle(2);
        i_rst = 1'b0;

        rd("rst_status", STAT, 0, 0);
        rd("rst_result3", RB + 3, 0, 0);
        rd("rst_weight0", WB, 0, 0);
        rd("rst_data", DB + 20, 0, 0);
        rd_re("rst_re0", STAT, 0, 0, 1'b0);
        rd("ctrl_idle", CTRL, 0, 0);

        // Basic run; upper write bits must be dropped so each weight is 1.
        load(32'hFFF1, 0, 1'b1);
        wr(CTRL, 1);
        rd("busy_after_start", STAT, 2, 2);
        idle(1);
        rd("partial_sum", RB + 7, 7, 7);
        idle(T - 3);
        rd("status_on_done_edge", STAT, 2, 2);
        rd("status_done", STAT, 1, 1);
        rd("status_cleared", STAT, 0, 0);
        check_results("basic_result", 9);

        run(3, 1, 1);
        check_results("accum_result", 18);
        run(1, 1, 1);
        check_results("reaccum_result", 9);

        // Writes and a second start while busy are dropped.
        wr(CTRL, 1);
        rd("ctrl_busy", CTRL, 1, 1);
        wr(WB, 15);
        wr(CTRL, 3);
        idle(T - 2);
        rd("busy_status", STAT, 1, 1);
        check_results("busy_result", 9);
        rd("busy_weight0", WB, 1, 1);

        wrd("raw_pre", WB + 1, 5, 1);
        rd("raw_post", WB + 1, 5, 5);
        wr(WB + 1, 1);

        rd("unmapped", 100, 0, 0);
        wr(RB + 5, 32'hABC);
        rd("result_ro", RB + 5, 45, 45);
        wr(100, 7);
        rd("unmapped_wr", 100, 0, 0);
        rd_re("re0", RB + 5, 0, 0, 1'b0);
        wr(STAT, 7);
        rd("status_ro", STAT, 0, 0);

        // Saturation vs wrap: 3 runs of 9*225 = 6075.
        load(15, 15, 1'b0);
        run(1, 1, 1);
        rd("sat_run1", RB, 2025, 2025);
        run(3, 1, 1);
        rd("sat_run2", RB + 2, 4050, 4050);
        run(3, 1, SatStatus);
        for (int l = 0; l < int'(L); l++) rd("sat_result", RB + l, 6075, SatResult);
        rd("sat_status_clr", STAT, 0, 0);

        // Reset at tap 4.
        wr(CTRL, 1);
        idle(4);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        rd("midrst_status", STAT, 0, 0);
        rd("midrst_result0", RB, 0, 0);
        rd("midrst_result7", RB + 7, 0, 0);
        rd("midrst_weight", WB + 4, 0, 0);
        rd("midrst_data", DB + 3 * T + 2, 0, 0);
        load(2, 0, 1'b1);
        run(1, 1, 1);
        check_results("post_rst_result", 18);

        idle(2);
        if (ea_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", ea_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
